// File: rtl/sdram_host_arbiter.sv
// Two-client (c0 video, c1 CPU) arbiter serialising transactions onto the sdram_controller host_* port.
// Latency: ack and host request appear 1 cycle after the grant edge; rvalid 1 cycle after host_rd_valid.
// Backpressure: no grant while host_busy=1 in IDLE or while a transaction is outstanding; timeout sets sticky timeout_err.
// Optional feature: define SDRAM_ARB_ROUND_ROBIN_EN for alternating tie-break instead of fixed c0 priority.
`default_nettype none

module sdram_host_arbiter #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT_W = 8
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_ack,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_rvalid,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_ack,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_rvalid,
    output logic              host_wr_req,
    output logic              host_rd_req,
    output logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_data_in,
    input  logic [DATA_W-1:0] host_data_out,
    input  logic              host_busy,
    input  logic              host_rd_valid,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    // Counter runs 0 .. 2**TIMEOUT_W-2 while requesting, so the request is held 2**TIMEOUT_W-1 cycles.
    localparam logic [TIMEOUT_W-1:0] T_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               state;
    logic [TIMEOUT_W-1:0] cnt;
    logic                 cur;      // client owning the outstanding transaction
    logic                 cur_rd;   // outstanding transaction is a read
    logic                 got;      // read data already captured
    logic                 pick;     // 1 = grant client 1

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic                 last_grant;

    // Tie goes to the client not granted last; a lone requester always wins.
    always_comb begin
        pick = !c0_req;
        if (c0_req && c1_req) pick = !last_grant;
    end
`else
    // Fixed priority: client 1 only when client 0 is idle.
    always_comb begin
        pick = !c0_req;
    end
`endif

    // Arbitration / transaction FSM with registered outputs.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            cur          <= 1'b0;
            cur_rd       <= 1'b0;
            got          <= 1'b0;
            c0_ack       <= 1'b0;
            c1_ack       <= 1'b0;
            c0_rvalid    <= 1'b0;
            c1_rvalid    <= 1'b0;
            c0_rdata     <= '0;
            c1_rdata     <= '0;
            host_wr_req  <= 1'b0;
            host_rd_req  <= 1'b0;
            host_addr    <= '0;
            host_data_in <= '0;
            timeout_err  <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            last_grant   <= 1'b1;   // first tie after reset goes to client 0
`endif
        end else begin
            c0_ack    <= 1'b0;
            c1_ack    <= 1'b0;
            c0_rvalid <= 1'b0;
            c1_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if ((c0_req || c1_req) && !host_busy) begin
                        cur   <= pick;
                        cnt   <= '0;
                        got   <= 1'b0;
                        state <= ISSUE;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                        last_grant <= pick;
`endif
                        if (pick) begin
                            c1_ack       <= 1'b1;
                            cur_rd       <= !c1_we;
                            host_wr_req  <= c1_we;
                            host_rd_req  <= !c1_we;
                            host_addr    <= c1_addr;
                            host_data_in <= c1_wdata;
                        end else begin
                            c0_ack       <= 1'b1;
                            cur_rd       <= !c0_we;
                            host_wr_req  <= c0_we;
                            host_rd_req  <= !c0_we;
                            host_addr    <= c0_addr;
                            host_data_in <= c0_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (host_busy) begin
                        host_wr_req <= 1'b0;
                        host_rd_req <= 1'b0;
                        state       <= BUSY;
                    end else if (cnt == T_LAST) begin
                        host_wr_req <= 1'b0;
                        host_rd_req <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BUSY: begin
                    if (cur_rd) begin
                        if (host_rd_valid && !got) begin
                            got <= 1'b1;
                            if (cur) begin
                                c1_rdata  <= host_data_out;
                                c1_rvalid <= 1'b1;
                            end else begin
                                c0_rdata  <= host_data_out;
                                c0_rvalid <= 1'b1;
                            end
                        end
                        // Busy release and data return may come in either order.
                        if (!host_busy && (got || host_rd_valid)) state <= IDLE;
                    end else if (!host_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sdram_host_arbiter.sv
// Directed and randomized bench for sdram_host_arbiter with an inline controller responder.
// Expected winner, host fields, rvalid routing, read data and timeout length come from a transaction-level model.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
`default_nettype none

module tb_sdram_host_arbiter;
    localparam int AW = 24;
    localparam int DW = 16;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic          rst;
    logic          rq [2];
    logic          wq [2];
    logic [AW-1:0] aq [2];
    logic [DW-1:0] dq [2];
    logic          c0_ack, c1_ack, c0_rvalid, c1_rvalid;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic          host_wr_req, host_rd_req, host_busy, host_rd_valid, timeout_err;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data_in, host_data_out;

    sdram_host_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(8)) dut (
        .clk_sys(clk_sys), .rst(rst),
        .c0_req(rq[0]), .c0_we(wq[0]), .c0_addr(aq[0]), .c0_wdata(dq[0]),
        .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid),
        .c1_req(rq[1]), .c1_we(wq[1]), .c1_addr(aq[1]), .c1_wdata(dq[1]),
        .c1_ack(c1_ack), .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
        .host_wr_req(host_wr_req), .host_rd_req(host_rd_req),
        .host_addr(host_addr), .host_data_in(host_data_in),
        .host_data_out(host_data_out), .host_busy(host_busy),
        .host_rd_valid(host_rd_valid), .timeout_err(timeout_err)
    );

    int            n_chk  = 0;
    int            n_fail = 0;
    int            last_win = 1;        // model: client granted most recently (1 => first tie to c0)
    logic [DW-1:0] exp_rd [2];
    logic          exp_terr;

    task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next;
        @(posedge clk_sys);
        #1;
        chk(32'(host_wr_req & host_rd_req), 0, "wr_rd_exclusive");
    endtask

    // One transaction from the current request inputs, with the controller responding as described by the args.
    task automatic serve(input int pre_busy, input int bdly, input int blen, input int rdv_off,
                         input bit never, input logic [DW-1:0] dat);
        int w, hi, last, p0, p1;
        bit rd;
        if (rq[0] && rq[1]) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            w = (last_win == 0) ? 1 : 0;
`else
            w = 0;
`endif
        end else begin
            w = rq[0] ? 0 : 1;
        end
        host_busy = (pre_busy > 0);
        for (int k = 0; k < pre_busy; k++) begin
            next;
            chk({c1_ack, c0_ack}, 0, "no_ack_while_busy");
            if (k == pre_busy - 1) host_busy = 1'b0;
        end
        next;
        chk({c1_ack, c0_ack}, 32'(1) << w, "ack_winner");
        chk(host_addr, aq[w], "grant_addr");
        chk(host_wr_req, wq[w], "grant_wr_req");
        chk(host_rd_req, !wq[w], "grant_rd_req");
        if (wq[w]) chk(host_data_in, dq[w], "grant_wdata");
        last_win = w;
        rd = !wq[w];
        rq[w] = 1'b0;

        if (never) begin
            hi = 0;
            for (int k = 0; k < 300 && (host_wr_req || host_rd_req); k++) begin
                hi++;
                next;
            end
            chk(hi, 255, "timeout_req_cycles");
            chk(timeout_err, 1, "timeout_err_set");
            chk({c1_rvalid, c0_rvalid}, 0, "timeout_no_rvalid");
            exp_terr = 1'b1;
            return;
        end

        for (int k = 0; k < bdly; k++) begin
            next;
            chk({host_wr_req, host_rd_req}, {wq[w], !wq[w]}, "req_held");
            chk(host_addr, aq[w], "addr_held");
            chk({c1_ack, c0_ack}, 0, "ack_single_pulse");
        end
        host_busy = 1'b1;
        last = blen - 1;
        if (rd && rdv_off > last) last = rdv_off;
        p0 = 0; p1 = 0;
        for (int i = 0; i <= last + 1; i++) begin
            next;
            host_rd_valid = 1'b0;
            if (i == 0) chk({host_wr_req, host_rd_req}, 0, "req_dropped");
            chk({c1_ack, c0_ack}, 0, "no_ack_in_busy");
            p0 += int'(c0_rvalid);
            p1 += int'(c1_rvalid);
            if (rd && i == rdv_off + 1) chk((w == 1) ? c1_rdata : c0_rdata, dat, "rdata_value");
            if (i == rdv_off && (rd || rdv_off < blen)) begin
                host_rd_valid = 1'b1;
                host_data_out = dat;
            end
            if (i == blen - 1) host_busy = 1'b0;
        end
        if (rd) exp_rd[w] = dat;
        chk(p0, (rd && w == 0) ? 1 : 0, "c0_rvalid_pulses");
        chk(p1, (rd && w == 1) ? 1 : 0, "c1_rvalid_pulses");
        chk(c0_rdata, exp_rd[0], "c0_rdata_hold");
        chk(c1_rdata, exp_rd[1], "c1_rdata_hold");
        chk(timeout_err, exp_terr, "timeout_err_state");
    endtask

    task automatic set_req(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq[c] = 1'b1; wq[c] = we; aq[c] = a; dq[c] = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({host_wr_req, host_rd_req, c0_ack, c1_ack, c0_rvalid, c1_rvalid, timeout_err}, 0, tag);
        chk({c0_rdata, c1_rdata}, 0, tag);
        chk(host_addr, 0, tag);
        chk(host_data_in, 0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, bl;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 1'b0; wq[i] = 1'b0; aq[i] = '0; dq[i] = '0; exp_rd[i] = '0;
        end
        exp_terr = 1'b0;
        host_busy = 1'b0; host_rd_valid = 1'b0; host_data_out = '0;
        repeat (3) next;
        chk_all_zero("reset_state");
        rst = 1'b0;
        next;

        // c0 write, busy 2 cycles after request for 4 cycles
        set_req(0, 1'b1, 24'h000123, 16'hBEEF);
        serve(0, 2, 4, 0, 1'b0, 16'h0);
        // c1 read, data before busy falls
        set_req(1, 1'b0, 24'h00FFFF, 16'h0);
        serve(0, 1, 4, 1, 1'b0, 16'h1234);
        // c1 read with data after busy falls
        set_req(1, 1'b0, 24'h000042, 16'h0);
        serve(0, 0, 2, 3, 1'b0, 16'h5A5A);

        // simultaneous reads, tie repeated
        set_req(0, 1'b0, 24'h000010, 16'h0);
        set_req(1, 1'b0, 24'h000020, 16'h0);
        serve(0, 1, 2, 0, 1'b0, 16'hA001);
        for (int r = 0; r < 2; r++) begin
            if (!rq[0]) set_req(0, 1'b0, 24'h000011 + 24'(r), 16'h0);
            if (!rq[1]) set_req(1, 1'b0, 24'h000021 + 24'(r), 16'h0);
            serve(0, 1, 2, 0, 1'b0, 16'hA002 + 16'(r));
        end
        while (rq[0] || rq[1]) serve(0, 0, 1, 0, 1'b0, 16'hA00F);

        // busy in IDLE holds off the grant
        set_req(0, 1'b0, 24'h0000AA, 16'h0);
        serve(3, 0, 3, 1, 1'b0, 16'hC0DE);

        // controller never responds
        set_req(1, 1'b1, 24'h0BAD00, 16'h7777);
        serve(0, 0, 0, 0, 1'b1, 16'h0);
        set_req(0, 1'b1, 24'h000777, 16'h1111);
        serve(0, 1, 2, 0, 1'b0, 16'h0);

        // reset in the middle of a read
        set_req(0, 1'b0, 24'h000300, 16'h0);
        next;
        chk({c1_ack, c0_ack}, 1, "rst_test_ack");
        rq[0] = 1'b0;
        host_busy = 1'b1;
        next;
        next;
        rst = 1'b1;
        next;
        chk_all_zero("reset_mid_read");
        rst = 1'b0;
        host_busy = 1'b0;
        host_rd_valid = 1'b1;
        host_data_out = 16'hDEAD;
        next;
        host_rd_valid = 1'b0;
        next;
        chk({c1_rvalid, c0_rvalid}, 0, "late_rd_valid_ignored");
        chk({c0_rdata, c1_rdata}, 0, "late_rd_valid_rdata");
        exp_rd[0] = '0; exp_rd[1] = '0; exp_terr = 1'b0; last_win = 1;

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 2; k++)
                if (!rq[k] && $urandom_range(0, 1) == 1)
                    set_req(k, 1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom));
            if (!rq[0] && !rq[1]) begin
                c = int'($urandom_range(0, 1));
                set_req(c, 1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom));
            end
            bl = int'($urandom_range(1, 5));
            serve(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                  int'($urandom_range(0, 3)), bl, int'($urandom_range(0, bl + 1)),
                  1'b0, 16'($urandom));
        end
        while (rq[0] || rq[1]) serve(0, 0, 2, 0, 1'b0, 16'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
